fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin write arbiter that lets several producers share one synchronous FIFO write port. Each requester presents data with a valid/ready handshake. The arbiter grants one requester at a time for a burst of up to MAX_BURST beats and drives the FIFO's write_en/data_in directly. Backpressure comes from the FIFO's combinational full flag. It sits between the producer blocks and the FIFO instance, which keeps its Depth/Data_width configuration.

## Interface
- NUM_REQ, default 4: number of requesters, minimum 2.
- DATA_WIDTH, default 16: beat width; must equal the FIFO Data_width.
- MAX_BURST, default 4: maximum beats accepted per grant, minimum 1.
- GW (localparam) = max(1, $clog2(NUM_REQ)).
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  bit i: requester i has a beat.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i data at [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot or zero; bit i means requester i's beat is taken this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_write_en  out  1  FIFO write strobe.
- fifo_data_in  out  DATA_WIDTH  FIFO write data.
- grant_valid  out  1  a requester currently owns the write port.
- grant_id  out  GW  index of the owner; 0 when grant_valid=0.

## Operation
- Registers:
  - state: IDLE or GRANT.
  - owner [GW].
  - rr_ptr [GW]: highest-priority index for the next arbitration.
  - burst_cnt: holds 0..MAX_BURST-1.
- accept = !reset & (state==GRANT) & req_valid[owner] & !fifo_full (combinational).
- Combinational outputs:
  - fifo_write_en = accept.
  - req_ready[owner] = accept; all other bits 0.
  - fifo_data_in = req_data slice of owner; all zeros when state==IDLE.
  - grant_valid = (state==GRANT); grant_id = owner when grant_valid, else 0.
- IDLE:
  - If any req_valid is set, owner <= the first set index searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - burst_cnt <= 0, state <= GRANT.
  - Otherwise remain in IDLE.
- GRANT:
  - On accept with burst_cnt==MAX_BURST-1: release.
  - On accept otherwise: burst_cnt += 1.
  - If req_valid[owner]=0: release in that cycle; no beat is transferred.
  - If fifo_full=1 with req_valid[owner]=1: stall. State, owner and burst_cnt hold, with no timeout.
- Release: state <= IDLE, rr_ptr <= (owner+1) mod NUM_REQ, burst_cnt <= 0.
- Requesters not owning the grant are never acked. Their req_valid and req_data must hold until acked; the arbiter does not buffer.
- A stalled owner keeps its grant. Other requesters wait, but no beats are lost or reordered.

## Timing
- Reset (cycle with reset high, and after it): state IDLE, owner 0, rr_ptr 0, burst_cnt 0.
- Output values while reset is high: req_ready=0, fifo_write_en=0, fifo_data_in=0, grant_valid=0, grant_id=0.
- Reset mid-burst: the write is suppressed in the reset cycle itself. No further beats are taken until a fresh arbitration.
- Grant latency: req_valid seen in IDLE at edge k, so grant_valid=1 in cycle k+1. The first beat can be written in cycle k+1.
- Burst throughput: 1 beat/cycle while granted and not full.
- Bubble: exactly one IDLE cycle between consecutive grants, so peak utilisation is MAX_BURST/(MAX_BURST+1).
- Full handling: fifo_full is sampled in the same cycle, and the write is gated combinationally. The FIFO never sees write_en=1 while full=1.
- Wrap-around: rr_ptr wraps NUM_REQ-1 → 0. With NUM_REQ not a power of two, the modulo is explicit.
- Fairness: a continuously requesting set of N requesters is each granted once every N grants.

## Test plan
- Reset: assert reset 2 cycles with all req_valid=1 → every output is 0 in both cycles, and grant_id=0, grant_valid=1 one cycle after reset drops.
- Single requester: req_valid=4'b0100, 8 beats 0x0001..0x0008, MAX_BURST=4, FIFO empty → beats written in order as 4, 1 idle cycle, 4.
- Round robin: req_valid=4'b1111 held, MAX_BURST=4 → grant_id sequence 0,1,2,3,0, each a 4-beat burst; fifo_write_en shows a one-cycle gap between bursts.
- Full stall: FIFO pre-filled to 1 slot free, requester 1 bursting → one write, then fifo_write_en=0 and req_ready=0 while full. Grant is held at id 1; after one FIFO read the next beat is written on the following cycle.
- Early release: requester 2 drops req_valid after 2 beats while requester 3 waits → release, one IDLE cycle, then grant_id=3 with burst_cnt restarting at 0.
- Mid-burst reset: reset asserted during beat 2 of 4 → fifo_write_en=0 in the reset cycle, and the next grant after reset starts from rr_ptr=0.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ
// valid/ready producers, granting bursts of up to MAX_BURST beats.
module fifo_write_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned MAX_BURST  = 4,
   localparam int unsigned GW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_write_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   output logic                          grant_valid,
   output logic [GW-1:0]                 grant_id
);

   localparam int unsigned BW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                  state;
   logic [GW-1:0]           owner;
   logic [GW-1:0]           rr_ptr;
   logic [BW-1:0]           burst_cnt;

   logic [NUM_REQ-1:0]      rot;
   logic [GW-1:0]           pick;
   logic                    any_req;
   int unsigned             pick_sum;
   logic                    owner_valid;
   logic [DATA_WIDTH-1:0]   owner_data;
   logic                    accept;
   logic                    burst_last;
   logic [GW-1:0]           next_rr;

   // Rotate requests so bit 0 is rr_ptr, then take the lowest set bit
   always_comb begin
      rot      = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
      any_req  = 1'b0;
      pick_sum = 0;
      pick     = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (!any_req && rot[j]) begin
            any_req  = 1'b1;
            pick_sum = 32'(rr_ptr) + j;
            if (pick_sum >= NUM_REQ) begin
               pick_sum = pick_sum - NUM_REQ;
            end
         end
      end
      pick = GW'(pick_sum);
   end

   // Owner's valid bit and data slice
   always_comb begin
      owner_valid = 1'b0;
      owner_data  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (owner == GW'(i)) begin
            owner_valid = req_valid[i];
            owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign accept     = !reset && (state == GRANT) && owner_valid && !fifo_full;
   assign burst_last = (burst_cnt == BW'(MAX_BURST - 1));
   assign next_rr    = (owner == GW'(NUM_REQ - 1)) ? '0 : owner + GW'(1);

   always_comb begin
      req_ready = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = accept && (owner == GW'(i));
      end
   end

   assign fifo_write_en = accept;
   assign grant_valid   = !reset && (state == GRANT);
   assign grant_id      = grant_valid ? owner : '0;
   assign fifo_data_in  = grant_valid ? owner_data : '0;

   // Grant FSM: a full FIFO stalls the owner indefinitely; a dropped valid releases
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner     <= pick;
                  burst_cnt <= '0;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (!owner_valid || (accept && burst_last)) begin
                  state     <= IDLE;
                  rr_ptr    <= next_rr;
                  burst_cnt <= '0;
               end else if (accept) begin
                  burst_cnt <= burst_cnt + BW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: per-requester expected beat queues,
// rule-level grant/round-robin model, directed scenarios plus random traffic.
module tb_fifo_write_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int MB = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            fifo_full;
   logic            fifo_write_en;
   logic [DW-1:0]   fifo_data_in;
   logic            grant_valid;
   logic [1:0]      grant_id;

   fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_full(fifo_full), .fifo_write_en(fifo_write_en),
      .fifo_data_in(fifo_data_in), .grant_valid(grant_valid), .grant_id(grant_id));

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Beat storage: wr_p = pushed, src_p = acked by producer, exp_p = seen at FIFO
   logic [DW-1:0] mem [N][256];
   int wr_p  [N];
   int src_p [N];
   int exp_p [N];
   int gap_pct = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
   endtask

   task automatic push(input int r, input logic [DW-1:0] d);
      mem[r][wr_p[r] % 256] = d;
      wr_p[r]++;
   endtask

   function automatic int rr_pick(input int rr, input logic [N-1:0] p);
      for (int i = 0; i < N; i++) begin
         int idx;
         idx = (rr + i) % N;
         if (p[idx]) return idx;
      end
      return 0;
   endfunction

   // Producers: hold valid/data until acked, optional random gaps between beats
   initial begin
      logic [N-1:0] ack_s;
      req_valid = '0;
      req_data  = '0;
      forever begin
         @(negedge clk);
         ack_s = req_ready;
         @(posedge clk);
         #1;
         for (int r = 0; r < N; r++) begin
            if (req_valid[r] && ack_s[r]) begin
               src_p[r]++;
               req_valid[r] = 1'b0;
            end
            if (!req_valid[r] && src_p[r] < wr_p[r] &&
                $urandom_range(0, 99) >= 32'(gap_pct)) begin
               req_valid[r] = 1'b1;
               req_data[r*DW +: DW] = mem[r][src_p[r] % 256];
            end
         end
      end
   end

   // Monitor: checks every cycle against the arbitration rules and beat queues
   bit         prev_rst = 1'b1;
   bit         prev_gv, prev_own_valid, prev_we;
   logic [1:0] prev_gid;
   logic [N-1:0] pend;
   int         beats, prev_beats, rr_m;

   always @(negedge clk) begin
      bit exp_we, released;
      if (reset) begin
         chk("reset_outs", {8'h0, req_ready, fifo_write_en, fifo_data_in, grant_valid, grant_id}, 0);
         rr_m     = 0;
         prev_gv  = 1'b0;
         prev_rst = 1'b1;
      end else begin
         exp_we = grant_valid && req_valid[grant_id] && !fifo_full;
         chk("write_en", 32'(fifo_write_en), 32'(exp_we));
         chk("req_ready", 32'(req_ready), exp_we ? (32'd1 << grant_id) : 32'd0);
         if (fifo_write_en) chk("write_while_full", 32'(fifo_full), 0);
         if (!grant_valid) chk("idle_outs", {14'h0, fifo_data_in, grant_id}, 0);
         if (!prev_rst) begin
            if (!prev_gv) begin
               chk("grant_start", 32'(grant_valid), 32'(pend != 0));
               if (grant_valid) begin
                  chk("grant_rr", 32'(grant_id), 32'(rr_pick(rr_m, pend)));
                  beats = 0;
               end
            end else begin
               released = !prev_own_valid || (prev_we && prev_beats == MB);
               chk("grant_hold", 32'(grant_valid), 32'(!released));
               if (grant_valid) chk("owner_stable", 32'(grant_id), 32'(prev_gid));
               if (released) rr_m = (int'(prev_gid) + 1) % N;
            end
         end
         if (fifo_write_en) begin
            beats++;
            if (exp_p[grant_id] < wr_p[grant_id]) begin
               chk("data", 32'(fifo_data_in), 32'(mem[grant_id][exp_p[grant_id] % 256]));
               exp_p[grant_id]++;
            end else begin
               chk("unexpected_beat", 32'(grant_id), 32'hFFFF);
            end
         end
         prev_gv        = grant_valid;
         prev_gid       = grant_id;
         prev_own_valid = req_valid[grant_id];
         prev_we        = fifo_write_en;
         prev_beats     = beats;
         pend           = req_valid;
         prev_rst       = 1'b0;
      end
   end

   task automatic wait_grant(input int bound, output bit ok);
      bit prev;
      prev = 1'b1;
      ok   = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (grant_valid && !prev) begin
            ok = 1'b1;
            break;
         end
         prev = grant_valid;
      end
      if (!ok) chk("grant_timeout", 0, 1);
   endtask

   task automatic wait_drain(input string nm, input int bound);
      bit done;
      done = 1'b0;
      for (int i = 0; i < bound && !done; i++) begin
         @(negedge clk);
         done = !grant_valid;
         for (int r = 0; r < N; r++) if (src_p[r] != wr_p[r]) done = 1'b0;
      end
      chk({nm, "_drain"}, 32'(done), 1);
      for (int r = 0; r < N; r++) chk({nm, "_all_beats"}, 32'(exp_p[r]), 32'(wr_p[r]));
   endtask

   initial begin
      bit ok;
      logic [24:0] we_v, exp_v;
      int ids[$];
      reset     = 1'b1;
      fifo_full = 1'b0;
      for (int r = 0; r < N; r++) begin
         wr_p[r] = 0; src_p[r] = 0; exp_p[r] = 0;
      end

      // Reset with everybody requesting, then round robin 0,1,2,3,0
      for (int r = 0; r < N; r++)
         for (int k = 0; k < 8; k++) push(r, DW'(r * 256 + k + 1));
      repeat (2) begin
         @(negedge clk);
         chk("rst_hold_outs", {req_ready, fifo_write_en, grant_valid}, 0);
      end
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", 32'(grant_valid), 0);
      @(negedge clk);
      chk("post_rst_gv", 32'(grant_valid), 1);
      chk("post_rst_gid", 32'(grant_id), 0);
      we_v = '0; exp_v = '0;
      for (int c = 0; c < 25; c++) begin
         if (c > 0) @(negedge clk);
         if (c % 5 == 0) ids.push_back(int'(grant_id));
         we_v  = {we_v[23:0], fifo_write_en};
         exp_v = {exp_v[23:0], (c % 5) != 4};
      end
      chk("rr_we_pattern", 32'(we_v), 32'(exp_v));
      chk("rr_id0", 32'(ids[0]), 0);
      chk("rr_id1", 32'(ids[1]), 1);
      chk("rr_id2", 32'(ids[2]), 2);
      chk("rr_id3", 32'(ids[3]), 3);
      chk("rr_id4", 32'(ids[4]), 0);
      wait_drain("rr", 300);

      // Single requester 2, 8 beats: 4, bubble, 4
      for (int k = 1; k <= 8; k++) push(2, DW'(k));
      wait_grant(100, ok);
      we_v = '0;
      for (int c = 0; c < 9; c++) begin
         if (c > 0) @(negedge clk);
         we_v = {we_v[23:0], fifo_write_en};
      end
      chk("single_we_pattern", 32'(we_v), 32'h1EF);
      wait_drain("single", 200);

      // Full stall on requester 1
      for (int k = 0; k < 4; k++) push(1, DW'(16'hA0 + k));
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = fifo_write_en;
      end
      chk("stall_first_write", 32'(ok), 1);
      @(posedge clk); #1 fifo_full = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_we", 32'(fifo_write_en), 0);
         chk("stall_ready", 32'(req_ready), 0);
         chk("stall_gv", 32'(grant_valid), 1);
         chk("stall_gid", 32'(grant_id), 1);
      end
      @(posedge clk); #1 fifo_full = 1'b0;
      @(negedge clk);
      chk("stall_resume_we", 32'(fifo_write_en), 1);
      chk("stall_resume_gid", 32'(grant_id), 1);
      wait_drain("stall", 200);

      // Early release: requester 2 has 2 beats, requester 3 waits
      for (int k = 0; k < 2; k++) push(2, DW'(16'hB0 + k));
      for (int k = 0; k < 4; k++) push(3, DW'(16'hC0 + k));
      wait_grant(100, ok);
      chk("early_first_gid", 32'(grant_id), 2);
      we_v = '0;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 4) chk("early_second_gid", {30'h0, grant_valid, grant_id[0]}, 3);
         we_v = {we_v[23:0], fifo_write_en};
      end
      chk("early_we_pattern", 32'(we_v), 32'hCF);
      wait_drain("early", 200);

      // Reset during beat 2 of requester 2's burst
      for (int r = 0; r < N; r++)
         for (int k = 0; k < 8; k++) push(r, DW'(16'hD000 + r * 16 + k));
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         ok = grant_valid && grant_id == 2'd2 && fifo_write_en;
      end
      chk("midrst_found", 32'(ok), 1);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("midrst_we", 32'(fifo_write_en), 0);
      @(posedge clk); #1 reset = 1'b0;
      wait_grant(100, ok);
      chk("midrst_regrant_gid", 32'(grant_id), 0);
      wait_drain("midrst", 400);

      // Random traffic, gaps, full flag and occasional reset
      gap_pct = 30;
      for (int c = 0; c < 2500; c++) begin
         @(posedge clk); #1;
         fifo_full = ($urandom_range(0, 3) == 0);
         reset     = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 4) == 0) begin
            int r, n;
            r = int'($urandom_range(0, N - 1));
            n = int'($urandom_range(1, 6));
            if (wr_p[r] - src_p[r] < 100)
               for (int k = 0; k < n; k++) push(r, DW'($urandom));
         end
      end
      @(posedge clk); #1;
      fifo_full = 1'b0;
      reset     = 1'b0;
      wait_drain("random", 3000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
